// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port DMEM between the core MEM stage and an ext loader/debug port.
// Build option: define DMEM_ARB_FAIR_EN to enable ext starvation avoidance (wait_cnt + ARB_EXT state);
// without it the core has strict priority and never stalls.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                core_req,
  input  logic                core_we,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic [DATA_W/8-1:0] core_be,
  output logic                core_gnt,
  output logic                core_stall,
  output logic                core_rvalid,
  output logic [DATA_W-1:0]   core_rdata,
  input  logic                ext_req,
  input  logic                ext_we,
  input  logic [ADDR_W-1:0]   ext_addr,
  input  logic [DATA_W-1:0]   ext_wdata,
  input  logic [DATA_W/8-1:0] ext_be,
  output logic                ext_gnt,
  output logic                ext_rvalid,
  output logic [DATA_W-1:0]   ext_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);
  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("dmem_arbiter: MAX_WAIT must be in 1..15");
  end

  typedef enum logic [1:0] {RD_NONE, RD_CORE, RD_EXT} owner_t;
  owner_t rd_owner, rd_owner_nx;

`ifdef DMEM_ARB_FAIR_EN
  typedef enum logic {ARB_CORE, ARB_EXT} state_t;
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
  localparam logic [3:0] WAIT_TH  = 4'(MAX_WAIT - 1);
  state_t     state, state_nx;
  logic [3:0] wait_cnt, wait_cnt_nx;

  // arbitration state and ext wait counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ARB_CORE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  // grants, next state and wait counting; ARB_EXT lasts exactly one cycle
  always_comb begin
    core_gnt = core_req;
    ext_gnt  = ext_req & ~core_req;
    state_nx = state;
    if (state == ARB_EXT) begin
      ext_gnt  = ext_req;
      core_gnt = core_req & ~ext_req;
      state_nx = (ext_gnt | ~ext_req) ? ARB_CORE : ARB_EXT;
    end else if (ext_req & ~ext_gnt & (wait_cnt == WAIT_TH)) begin
      state_nx = ARB_EXT;
    end
    wait_cnt_nx = (ext_gnt | ~ext_req) ? 4'd0 : (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 4'd1;
    core_stall  = core_req & ~core_gnt;
  end
`else
  // strict core priority; the core is never denied
  always_comb begin
    core_gnt   = core_req;
    ext_gnt    = ext_req & ~core_req;
    core_stall = 1'b0;
  end
`endif

  // DMEM command mux: fields of the granted port, quiet strobes when idle
  always_comb begin
    mem_en      = core_gnt | ext_gnt;
    mem_we      = ext_gnt ? ext_we : core_gnt & core_we;
    mem_addr    = ext_gnt ? ext_addr : core_addr;
    mem_wdata   = ext_gnt ? ext_wdata : core_wdata;
    mem_be      = ext_gnt ? ext_be : core_gnt ? core_be : '0;
    rd_owner_nx = (core_gnt & ~core_we) ? RD_CORE : (ext_gnt & ~ext_we) ? RD_EXT : RD_NONE;
  end

  // remember who issued last cycle's load so its data can be qualified
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_owner <= RD_NONE;
    else          rd_owner <= rd_owner_nx;
  end

  assign core_rvalid = (rd_owner == RD_CORE);
  assign ext_rvalid  = (rd_owner == RD_EXT);
  assign core_rdata  = mem_rdata;
  assign ext_rdata   = mem_rdata;
endmodule
